// File: rtl/arb_pkg.sv
// arb_pkg
// Shared widths, the requester id type and the round-robin pick helper
// used by the four-input arbitrating multiplexer.
//   N_REQ   : number of requesters
//   DATA_W  : payload width per requester
//   req_id_t: requester index type
//   pick_t  : result of a round-robin search (found flag + winning id)
//   rr_pick : search valid bits starting at ptr, wrapping modulo N_REQ
package arb_pkg;

  localparam int N_REQ  = 4;
  localparam int DATA_W = 4;

  typedef logic [1:0] req_id_t;

  typedef struct packed {
    logic    found;
    req_id_t id;
  } pick_t;

  // The id wraps naturally because req_id_t is exactly log2(N_REQ) bits.
  // When nothing is valid the id stays 0 so downstream selects never see X.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] valid,
                                    input req_id_t ptr);
    pick_t   res;
    req_id_t idx;
    res.found = 1'b0;
    res.id    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ptr + req_id_t'(k);
      if (!res.found && valid[idx]) begin
        res.found = 1'b1;
        res.id    = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mux_4_1.sv
// mux_4_1
// Four-way payload selector built from two levels of 2:1 muxes.
//   d0..d3 : candidate payloads
//   sel    : index of the payload to pass through
//   y      : selected payload
module mux_4_1
  import arb_pkg::*;
(
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  input  logic [DATA_W-1:0] d2,
  input  logic [DATA_W-1:0] d3,
  input  logic [1:0]        sel,
  output logic [DATA_W-1:0] y
);

  logic [DATA_W-1:0] lo_pair;
  logic [DATA_W-1:0] hi_pair;

  // First level picks within each pair, second level picks the pair.
  assign lo_pair = sel[0] ? d1 : d0;
  assign hi_pair = sel[0] ? d3 : d2;
  assign y       = sel[1] ? hi_pair : lo_pair;

endmodule

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter
// Round-robin arbiter that funnels four valid/ready requesters into one
// registered output stage.
//   clk, rst       : clock and synchronous active-high reset
//   in_valid       : per-requester valid
//   in_data0..3    : per-requester payload
//   in_ready       : one-hot (or zero) grant back to the requesters
//   out_valid      : output register holds an item
//   out_ready      : downstream accepts the held item
//   out_data       : held payload
//   out_id         : requester that supplied the held payload
module rr_mux_arbiter
  import arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  in_valid,
  input  logic [DATA_W-1:0] in_data0,
  input  logic [DATA_W-1:0] in_data1,
  input  logic [DATA_W-1:0] in_data2,
  input  logic [DATA_W-1:0] in_data3,
  output logic [N_REQ-1:0]  in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_id
);

  req_id_t           ptr;
  pick_t             pick;
  logic              can_accept;
  logic [DATA_W-1:0] grant_data;

  // The output slot is free if empty or being drained this cycle, so a new
  // item can replace the old one without a bubble. in_ready depends only on
  // in_valid, ptr, out_valid and out_ready -- never on out_data.
  always_comb begin
    can_accept = !out_valid || out_ready;
    pick       = rr_pick(in_valid, ptr);
    in_ready   = '0;
    if (!rst && can_accept && pick.found) begin
      in_ready[pick.id] = 1'b1;
    end
  end

  mux_4_1 u_mux (
    .d0  (in_data0),
    .d1  (in_data1),
    .d2  (in_data2),
    .d3  (in_data3),
    .sel (pick.id),
    .y   (grant_data)
  );

  // Output register and round-robin pointer. The pointer moves only on an
  // input transfer; an empty accept cycle just clears out_valid, and a
  // stalled cycle leaves everything untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      ptr       <= '0;
    end else if (can_accept) begin
      if (pick.found) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_id    <= pick.id;
        ptr       <= pick.id + 2'd1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter
// Directed bench for rr_mux_arbiter: a reference model of the arbiter
// rules is checked every cycle, a scoreboard checks in-order single
// delivery, and directed scenarios carry hand-computed expectations.
module tb_rr_mux_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_valid;
  logic [3:0] d [4];
  logic [3:0] in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [1:0] out_id;

  int vec_count  = 0;
  int miss_count = 0;

  // Reference state: what the output register and pointer should hold.
  bit         check_en = 1'b0;
  bit         m_ov     = 1'b0;
  logic [3:0] m_data   = 4'h0;
  int         m_id     = 0;
  int         m_ptr    = 0;
  logic [5:0] sb [$];

  bit         n_found;
  int         n_g;
  logic [3:0] n_rdy;
  logic [5:0] n_item;
  bit         p_found;
  int         p_g;

  rr_mux_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data0  (d[0]),
    .in_data1  (d[1]),
    .in_data2  (d[2]),
    .in_data3  (d[3]),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id)
  );

  always #5 clk = ~clk;

  // First valid requester scanning ptr, ptr+1, ... modulo 4.
  function automatic void model_grant(input logic [3:0] v, input int p,
                                      output bit found, output int g);
    found = 1'b0;
    g     = 0;
    for (int k = 0; k < 4; k++) begin
      if (!found && v[(p + k) % 4]) begin
        found = 1'b1;
        g     = (p + k) % 4;
      end
    end
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] act,
                             input logic [7:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] v,
                               input logic ordy);
    rst       = r;
    in_valid  = v;
    out_ready = ordy;
    #1;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkHeld(input string name, input logic ov,
                           input logic [1:0] id, input logic [3:0] data);
    checkOutput({name, "_valid"}, 8'(out_valid), 8'(ov));
    checkOutput({name, "_id"},    8'(out_id),    8'(id));
    checkOutput({name, "_data"},  8'(out_data),  8'(data));
  endtask

  // Advance the reference model on each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      m_ov     = 1'b0;
      m_data   = 4'h0;
      m_id     = 0;
      m_ptr    = 0;
      sb.delete();
      check_en = 1'b1;
    end else if (!m_ov || out_ready) begin
      model_grant(in_valid, m_ptr, p_found, p_g);
      if (p_found) begin
        sb.push_back({2'(p_g), d[p_g]});
        m_data = d[p_g];
        m_id   = p_g;
        m_ov   = 1'b1;
        m_ptr  = (p_g + 1) % 4;
      end else begin
        m_ov = 1'b0;
      end
    end
  end

  // Compare DUT against the model mid-cycle, and pop the scoreboard for
  // any item that the next edge will hand downstream.
  always @(negedge clk) begin
    if (check_en) begin
      model_grant(in_valid, m_ptr, n_found, n_g);
      n_rdy = (!rst && (!m_ov || out_ready) && n_found) ? 4'(1 << n_g) : 4'b0000;
      checkOutput("model_in_ready",  8'(in_ready),  8'(n_rdy));
      checkOutput("model_out_valid", 8'(out_valid), 8'(m_ov));
      checkOutput("model_out_data",  8'(out_data),  8'(m_data));
      checkOutput("model_out_id",    8'(out_id),    8'(m_id));
      if (out_valid === 1'b1 && out_ready && !rst) begin
        if (sb.size() == 0) begin
          checkOutput("sb_unexpected", 8'(out_data), 8'hFF);
        end else begin
          n_item = sb.pop_front();
          checkOutput("sb_item", 8'({out_id, out_data}), 8'(n_item));
        end
      end
    end
  end

  initial begin
    d[0] = 4'hA; d[1] = 4'hB; d[2] = 4'hC; d[3] = 4'hD;

    // Reset held two cycles while everyone is requesting.
    applyStimulus(1'b1, 4'b1111, 1'b1);
    checkOutput("rst_in_ready", 8'(in_ready), 8'h00);
    stepCycle();
    stepCycle();
    checkHeld("rst", 1'b0, 2'd0, 4'h0);
    applyStimulus(1'b0, 4'b1111, 1'b1);
    checkOutput("first_grant", 8'(in_ready), 8'b0001);

    // Rotation with all requesters valid, one item per cycle.
    for (int k = 0; k < 5; k++) begin
      stepCycle();
      checkHeld("rot", 1'b1, 2'(k % 4), 4'(10 + k % 4));
    end

    // Skip pattern from ptr 0.
    applyStimulus(1'b1, 4'b0000, 1'b1);
    stepCycle();
    d[1] = 4'h1; d[3] = 4'h3;
    applyStimulus(1'b0, 4'b1010, 1'b1);
    for (int k = 0; k < 4; k++) begin
      stepCycle();
      checkHeld("skip", 1'b1, (k % 2 == 0) ? 2'd1 : 2'd3, (k % 2 == 0) ? 4'h1 : 4'h3);
    end
    d[0] = 4'h8; d[2] = 4'h9;
    applyStimulus(1'b0, 4'b1111, 1'b1);
    checkOutput("skip_ptr0", 8'(in_ready), 8'b0001);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 4'b1111 << k, 1'b1);
      stepCycle();
      checkOutput("drain_id", 8'(out_id), 8'(k));
    end
    applyStimulus(1'b0, 4'b0000, 1'b1);
    stepCycle();

    // Backpressure with item (2, 5) held for three cycles.
    d[2] = 4'h5;
    applyStimulus(1'b0, 4'b0100, 1'b0);
    stepCycle();
    checkHeld("bp_load", 1'b1, 2'd2, 4'h5);
    d[3] = 4'h6;
    applyStimulus(1'b0, 4'b1000, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checkOutput("bp_in_ready", 8'(in_ready), 8'h00);
      stepCycle();
      checkHeld("bp_hold", 1'b1, 2'd2, 4'h5);
    end
    applyStimulus(1'b0, 4'b1000, 1'b1);
    checkOutput("bp_release", 8'(in_ready), 8'b1000);
    stepCycle();
    checkHeld("bp_next", 1'b1, 2'd3, 4'h6);
    applyStimulus(1'b0, 4'b0000, 1'b1);
    stepCycle();
    checkOutput("bp_empty", 8'(out_valid), 8'h00);

    // Single pulse then bubble; pointer should land on 3.
    d[2] = 4'h7;
    applyStimulus(1'b0, 4'b0100, 1'b1);
    stepCycle();
    checkHeld("pulse", 1'b1, 2'd2, 4'h7);
    applyStimulus(1'b0, 4'b0000, 1'b1);
    stepCycle();
    checkHeld("bubble", 1'b0, 2'd2, 4'h7);
    d[0] = 4'hE; d[3] = 4'hF;
    applyStimulus(1'b0, 4'b1001, 1'b1);
    checkOutput("bubble_ptr3", 8'(in_ready), 8'b1000);
    stepCycle();
    applyStimulus(1'b0, 4'b0001, 1'b1);
    stepCycle();
    checkHeld("wrap", 1'b1, 2'd0, 4'hE);
    applyStimulus(1'b0, 4'b0000, 1'b1);
    stepCycle();

    // Reset during a stall drops the held item.
    d[2] = 4'h5;
    applyStimulus(1'b0, 4'b0100, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 4'b0000, 1'b0);
    stepCycle();
    checkHeld("stall", 1'b1, 2'd2, 4'h5);
    applyStimulus(1'b1, 4'b0010, 1'b0);
    checkOutput("mrst_in_ready", 8'(in_ready), 8'h00);
    stepCycle();
    checkOutput("mrst_valid", 8'(out_valid), 8'h00);
    d[0] = 4'hA; d[1] = 4'hB; d[2] = 4'hC; d[3] = 4'hD;
    applyStimulus(1'b0, 4'b1111, 1'b1);
    checkOutput("mrst_grant", 8'(in_ready), 8'b0001);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 4'b1111 << k, 1'b1);
      stepCycle();
      checkHeld("mrst_rot", 1'b1, 2'(k), 4'(10 + k));
    end
    applyStimulus(1'b0, 4'b0000, 1'b1);
    stepCycle();
    stepCycle();
    checkOutput("sb_empty", 8'(sb.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
